// File: rtl/nibble_serial_add_ctrl_if.sv
// Handshake and operand/result bus for the nibble-serial add/sub controller.
interface nibble_serial_add_ctrl_if #(
  parameter int WORDS = 4
);
  localparam int W = 4 * WORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, op_a, op_b,
    input  ready, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output ready, done, result, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder/subtractor: one 4-bit ripple-carry adder is reused
// for WORDS passes, LSB nibble first, with the carry kept in a register.

// 4-bit ripple-carry adder, one full adder per bit.
module Ripple_Carry (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];
endmodule

module nibble_serial_add_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [WORDS-1:0][3:0] a_q, b_q, res_q;
  logic                  sub_q, carry_q, cout_q, ovf_q;
  logic [IDX_W-1:0]      idx;

  logic       accept, step, last, ready_c, done_c;
  logic [3:0] a_n, b_n, sum_n;
  logic       c_out;

  // Current nibble pair; subtraction is A + ~B + 1 with the +1 as carry-in.
  assign a_n  = a_q[idx];
  assign b_n  = sub_q ? ~b_q[idx] : b_q[idx];
  assign last = (idx == LAST);

  Ripple_Carry u_rca (
    .a    (a_n),
    .b    (b_n),
    .cin  (carry_q),
    .sum  (sum_n),
    .cout (c_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs; DONE accepts a new start directly.
  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    done_c    = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        ready_c = 1'b1;
        done_c  = 1'b1;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, one nibble pass per RUN cycle. The index
  // holds at the last nibble rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      a_q     <= bus.op_a;
      b_q     <= bus.op_b;
      sub_q   <= bus.sub;
      carry_q <= bus.sub;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx     <= '0;
    end else if (step) begin
      res_q[idx] <= sum_n;
      carry_q    <= c_out;
      if (last) begin
        cout_q <= c_out;
        ovf_q  <= (a_n[3] == b_n[3]) && (sum_n[3] != a_n[3]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.ready  = ready_c;
  assign bus.done   = done_c;
  assign bus.result = res_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl with hand-computed results.
module tb_nibble_serial_add_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  nibble_serial_add_ctrl_if #(.WORDS(4)) bus ();

  nibble_serial_add_ctrl #(.WORDS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // From the accepting edge: four busy cycles, then the done cycle.
  task automatic expect_done(input string tag, input logic [15:0] er,
                             input logic ec, input logic eo);
    int busy;
    busy = 0;
    repeat (4) begin
      @(negedge clk);
      if (!bus.ready && !bus.done) busy++;
    end
    chk({tag, "_busy"}, busy, 4);
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, bus.done}, 1);
    chk({tag, "_res"},  {16'd0, bus.result}, {16'd0, er});
    chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
    chk({tag, "_ovf"},  {31'd0, bus.ovf},  {31'd0, eo});
  endtask

  // Called at a negedge with ready=1; ends at the done-cycle negedge.
  task automatic run_op(input string tag, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er,
                        input logic ec, input logic eo);
    bus.start = 1'b1;
    bus.sub   = s;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.sub   = ~s;
    bus.op_a  = 16'hDEAD;
    bus.op_b  = 16'hBEEF;
    expect_done(tag, er, ec, eo);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_idle_done"},  {31'd0, bus.done}, 0);
    chk({tag, "_idle_ready"}, {31'd0, bus.ready}, 1);
  endtask

  initial begin
    int dones;
    int first;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready",  {31'd0, bus.ready}, 1);
    chk("rst_done",   {31'd0, bus.done}, 0);
    chk("rst_result", {16'd0, bus.result}, 0);
    chk("rst_cout",   {31'd0, bus.cout}, 0);
    chk("rst_ovf",    {31'd0, bus.ovf}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add, then a back-to-back start issued in the DONE cycle.
    run_op("add1234", 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.op_a  = 16'h0001;
    bus.op_b  = 16'h0001;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = 16'h5A5A;
    expect_done("b2b", 16'h0002, 1'b0, 1'b0);
    idle_check("b2b");

    run_op("addffff", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    idle_check("addffff");
    run_op("add7fff", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    idle_check("add7fff");
    run_op("sub5m7", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    idle_check("sub5m7");
    run_op("sub8000", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    idle_check("sub8000");

    // Start pulsed during RUN with different operands must be ignored.
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.op_a  = 16'h1111;
    bus.op_b  = 16'h2222;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = 1'b1;
    bus.op_a  = 16'hFFFF;
    bus.op_b  = 16'hFFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones = 0;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        if (first < 0) begin
          first = i;
          chk("ign_res", {16'd0, bus.result}, 32'h3333);
        end
      end
    end
    chk("ign_dones", dones, 1);
    chk("ign_when", first, 2);

    // Asynchronous reset in the second RUN cycle aborts the operation.
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.op_a  = 16'h1234;
    bus.op_b  = 16'h1111;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("partial_res", {16'd0, bus.result}, 32'h0005);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_result", {16'd0, bus.result}, 0);
    chk("arst_ready",  {31'd0, bus.ready}, 1);
    chk("arst_done",   {31'd0, bus.done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("arst_nodone", dones, 0);
    run_op("add3p4", 1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0);
    idle_check("add3p4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WORDS, default 4, giving the number of 4-bit nibble passes per operation; operand width is W = 4*WORDS.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, operation request, sampled only when ready=1.
REQ-005 The block SHALL have port sub, input, 1, operation select: 0 = A+B, 1 = A-B, latched with start.
REQ-006 The block SHALL have ports op_a and op_b, input, W each, operands, latched with start.
REQ-007 The block SHALL have port ready, output, 1, high when a start will be accepted.
REQ-008 The block SHALL have port done, output, 1, single-cycle completion pulse.
REQ-009 The block SHALL have port result, output, W, sum/difference, held until the next accepted start.
REQ-010 The block SHALL have ports cout and ovf, output, 1 each: final carry and signed overflow, held with result.

Function
REQ-011 The block SHALL instantiate exactly one 4-bit ripple-carry adder (team block Ripple_Carry) and time-share it across all nibble passes; no other adder logic is permitted on the data path.
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; ready=1 in IDLE and DONE, 0 in RUN.
REQ-013 Acceptance: start=1 at a rising edge with ready=1 SHALL latch op_a, op_b and sub, clear the nibble index to 0, load the carry register with sub, and enter RUN.
REQ-014 In RUN, each cycle SHALL present nibble k of A and nibble k of (sub ? ~B : B) with the carry register to the adder; at the edge, the sum nibble is written to result[4k+3:4k], the adder carry-out into the carry register, and k increments.
REQ-015 After the edge that processes nibble WORDS-1, the FSM SHALL enter DONE; done=1 for exactly that one cycle, with result, cout and ovf valid.
REQ-016 Latency: done SHALL be high in the cycle following the WORDS-th rising edge after the accepting edge (4 cycles for the default parameter).
REQ-017 cout SHALL equal the final carry (for sub, 1 = no borrow); ovf SHALL be 1 iff A[W-1] equals Beff[W-1] and result[W-1] differs from A[W-1], where Beff = sub ? ~B : B.
REQ-018 From DONE, start=1 SHALL be accepted at that edge (back-to-back operations, no idle cycle); otherwise the FSM returns to IDLE.
REQ-019 start while in RUN SHALL be ignored, with no effect on the operation in progress or on the latched operands.
REQ-020 Operand inputs changing after acceptance SHALL NOT affect the result.
REQ-021 Partial result bits SHALL be visible on result during RUN; consumers qualify result only with done.
REQ-022 Nibble index arithmetic SHALL be sized for WORDS and SHALL NOT wrap within an operation.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock, force FSM=IDLE, ready=1, done=0, result=0, cout=0, ovf=0, carry register=0, index=0.
REQ-024 A reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after deassertion SHALL behave normally.

Verification
REQ-025 add 0x1234+0x4321 -> result 0x5555, cout=0, ovf=0; done exactly 4 cycles after acceptance, ready=0 for those 4 cycles.
REQ-026 add 0xFFFF+0x0001 -> result 0x0000, cout=1, ovf=0; add 0x7FFF+0x0001 -> result 0x8000, cout=0, ovf=1.
REQ-027 sub 0x0005-0x0007 -> result 0xFFFE, cout=0, ovf=0; sub 0x8000-0x0001 -> result 0x7FFF, cout=1, ovf=1.
REQ-028 Back-to-back: start held high through the DONE cycle with new operands 0x0001+0x0001 -> second done pulse 4 cycles later with result 0x0002, no IDLE cycle in between.
REQ-029 start pulsed with different operands during RUN -> ignored; the original result is unchanged and only one done pulse occurs.
REQ-030 rst_n low during the 2nd RUN cycle -> result=0, ready=1, done=0 asynchronously; no done pulse follows; the next add 0x0003+0x0004 -> 0x0007.
